// File: rtl/hall_sector_decoder.sv
// hall_sector_decoder
//   Conditions the three raw Hall inputs (2-flop sync + stability filter) and
//   turns the filtered code into a rotor sector with direction, step strobe,
//   step-period measurement, stall detection and a sticky error flag.
// Ports:
//   CLK, RST_N        clock, async active-low reset
//   HALL[2:0]         raw Hall inputs {A,B,C}, asynchronous
//   CLR_ERR           synchronous clear of HALL_ERR (a same-cycle set wins)
//   SECTOR[2:0]       rotor sector 0..5, SECTOR_VALID when from a legal code
//   DIR               1 = forward (incrementing sector), 0 = reverse
//   STEP_STB          one-cycle pulse per adjacent-sector step
//   PERIOD            cycles between the last two same-direction steps
//   PERIOD_VALID      PERIOD holds a valid measurement
//   STALL             no step for STALL_CYCLES cycles
//   HALL_ERR          sticky: illegal code or skipped sector
module hall_sector_decoder #(
  parameter int FILTER_CYCLES = 16,
  parameter int PERIOD_W      = 24,
  parameter int STALL_CYCLES  = 1600000
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [2:0]          HALL,
  input  logic                CLR_ERR,
  output logic [2:0]          SECTOR,
  output logic                SECTOR_VALID,
  output logic                DIR,
  output logic                STEP_STB,
  output logic [PERIOD_W-1:0] PERIOD,
  output logic                PERIOD_VALID,
  output logic                STALL,
  output logic                HALL_ERR
);

  localparam int                 FCW        = $clog2(FILTER_CYCLES + 1);
  localparam logic [FCW-1:0]     FLT_LAST   = FCW'(FILTER_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
  localparam logic [PERIOD_W-1:0] STALL_LAST = PERIOD_W'(STALL_CYCLES - 1);

  // {legal, sector}
  function automatic logic [3:0] decode(input logic [2:0] c);
    case (c)
      3'b101:  decode = {1'b1, 3'd0};
      3'b100:  decode = {1'b1, 3'd1};
      3'b110:  decode = {1'b1, 3'd2};
      3'b010:  decode = {1'b1, 3'd3};
      3'b011:  decode = {1'b1, 3'd4};
      3'b001:  decode = {1'b1, 3'd5};
      default: decode = {1'b0, 3'd0};
    endcase
  endfunction

  logic [2:0]          sync1_q, sync1_d, sync2_q, sync2_d, cand_q, cand_d, filt_q, filt_d;
  logic                filt_none_q, filt_none_d;
  logic [FCW-1:0]      fcnt_q, fcnt_d;
  logic [2:0]          sector_q, sector_d;
  logic                sector_valid_q, sector_valid_d, dir_q, dir_d, step_stb_q, step_stb_d;
  logic [PERIOD_W-1:0] period_q, period_d, pcnt_q, pcnt_d;
  logic                period_valid_q, period_valid_d, stall_q, stall_d, hall_err_q, hall_err_d;
  logic                hist_vld_q, hist_vld_d, hist_dir_q, hist_dir_d;

  logic                accept, legal, err_set, fwd;
  logic [2:0]          new_sec;
  logic [3:0]          dec, diff_raw, diff;

  always_comb begin
    sync1_d        = HALL;
    sync2_d        = sync1_q;
    cand_d         = sync2_q;
    filt_d         = filt_q;
    filt_none_d    = filt_none_q;
    sector_d       = sector_q;
    sector_valid_d = sector_valid_q;
    dir_d          = dir_q;
    step_stb_d     = 1'b0;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    stall_d        = stall_q;
    hist_vld_d     = hist_vld_q;
    hist_dir_d     = hist_dir_q;
    err_set        = 1'b0;
    fwd            = 1'b0;

    // Stability counter: cleared on any disagreement, parks at FILTER_CYCLES-1.
    if (sync2_q != cand_q)      fcnt_d = '0;
    else if (fcnt_q == FLT_LAST) fcnt_d = fcnt_q;
    else                        fcnt_d = fcnt_q + FCW'(1);

    pcnt_d = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + PERIOD_W'(1);

    // Filtered-code update and output update share one edge to meet the
    // 2 + FILTER_CYCLES + 1 latency.
    accept   = (fcnt_q == FLT_LAST) && (filt_none_q || (cand_q != filt_q));
    dec      = decode(cand_q);
    legal    = dec[3];
    new_sec  = dec[2:0];
    diff_raw = {1'b0, new_sec} + 4'd6 - {1'b0, sector_q};
    diff     = (diff_raw >= 4'd6) ? diff_raw - 4'd6 : diff_raw;

    if (accept) begin
      filt_d      = cand_q;
      filt_none_d = 1'b0;
      if (!legal) begin
        sector_valid_d = 1'b0;
        period_valid_d = 1'b0;
        hist_vld_d     = 1'b0;
        err_set        = 1'b1;
        // Counter now times the invalid interval for the invalid-code stall.
        if (sector_valid_q) pcnt_d = '0;
      end else if (!sector_valid_q) begin
        sector_d       = new_sec;
        sector_valid_d = 1'b1;
        period_valid_d = 1'b0;
        hist_vld_d     = 1'b0;
        pcnt_d         = '0;
      end else if ((diff == 4'd1) || (diff == 4'd5)) begin
        fwd        = (diff == 4'd1);
        sector_d   = new_sec;
        dir_d      = fwd;
        step_stb_d = 1'b1;
        stall_d    = 1'b0;
        // A measurement needs an unbroken same-direction history; the step
        // ending a stall never qualifies.
        if (!stall_q && hist_vld_q && (hist_dir_q == fwd)) begin
          period_d       = (pcnt_q == CNT_MAX) ? CNT_MAX : pcnt_q + PERIOD_W'(1);
          period_valid_d = 1'b1;
        end else begin
          period_valid_d = 1'b0;
        end
        hist_vld_d = 1'b1;
        hist_dir_d = fwd;
        pcnt_d     = '0;
      end else begin
        sector_d       = new_sec;
        period_valid_d = 1'b0;
        hist_vld_d     = 1'b0;
        err_set        = 1'b1;
        pcnt_d         = '0;
      end
    end

    if (pcnt_d == STALL_LAST) begin
      stall_d        = 1'b1;
      period_valid_d = 1'b0;
    end

    if (err_set)      hall_err_d = 1'b1;
    else if (CLR_ERR) hall_err_d = 1'b0;
    else              hall_err_d = hall_err_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      cand_q         <= '0;
      fcnt_q         <= '0;
      filt_q         <= '0;
      filt_none_q    <= 1'b1;
      sector_q       <= '0;
      sector_valid_q <= 1'b0;
      dir_q          <= 1'b1;
      step_stb_q     <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      stall_q        <= 1'b0;
      hall_err_q     <= 1'b0;
      pcnt_q         <= '0;
      hist_vld_q     <= 1'b0;
      hist_dir_q     <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      cand_q         <= cand_d;
      fcnt_q         <= fcnt_d;
      filt_q         <= filt_d;
      filt_none_q    <= filt_none_d;
      sector_q       <= sector_d;
      sector_valid_q <= sector_valid_d;
      dir_q          <= dir_d;
      step_stb_q     <= step_stb_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      stall_q        <= stall_d;
      hall_err_q     <= hall_err_d;
      pcnt_q         <= pcnt_d;
      hist_vld_q     <= hist_vld_d;
      hist_dir_q     <= hist_dir_d;
    end
  end

  assign SECTOR       = sector_q;
  assign SECTOR_VALID = sector_valid_q;
  assign DIR          = dir_q;
  assign STEP_STB     = step_stb_q;
  assign PERIOD       = period_q;
  assign PERIOD_VALID = period_valid_q;
  assign STALL        = stall_q;
  assign HALL_ERR     = hall_err_q;

endmodule

// File: tb/tb_hall_sector_decoder.sv
// Bench for hall_sector_decoder (FILTER_CYCLES=4, STALL_CYCLES=1000).
// Step pulses are checked by a scoreboard; steady-state outputs by a vector
// table plus hand-written sequences for glitch, error, stall and reset cases.
module tb_hall_sector_decoder;
  localparam int PW = 24;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [2:0]    HALL = 3'b101;
  logic          CLR_ERR = 1'b0;
  logic [2:0]    SECTOR;
  logic          SECTOR_VALID, DIR, STEP_STB, PERIOD_VALID, STALL, HALL_ERR;
  logic [PW-1:0] PERIOD;

  hall_sector_decoder #(.FILTER_CYCLES(4), .PERIOD_W(PW), .STALL_CYCLES(1000)) dut (
    .CLK(CLK), .RST_N(RST_N), .HALL(HALL), .CLR_ERR(CLR_ERR),
    .SECTOR(SECTOR), .SECTOR_VALID(SECTOR_VALID), .DIR(DIR), .STEP_STB(STEP_STB),
    .PERIOD(PERIOD), .PERIOD_VALID(PERIOD_VALID), .STALL(STALL), .HALL_ERR(HALL_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]    sec;
    logic          dir;
    logic          pv;
    logic [PW-1:0] per;
  } step_t;

  typedef struct {
    logic [2:0]    hall;
    logic          step;
    logic [2:0]    sec;
    logic          dir;
    logic          pv;
    logic [PW-1:0] per;
  } vec_t;

  step_t sb_q[$];
  vec_t  vecs[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push_step(input logic [2:0] sec, input logic dir, input logic pv,
                           input logic [PW-1:0] per);
    step_t e;
    e.sec = sec; e.dir = dir; e.pv = pv; e.per = per;
    sb_q.push_back(e);
  endtask

  task automatic clr_pulse();
    CLR_ERR = 1'b1;
    tick(1);
    CLR_ERR = 1'b0;
  endtask

  // Scoreboard: every STEP_STB pulse must match the oldest expected step.
  always @(negedge CLK) begin
    step_t e;
    if (STEP_STB === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step: got STEP_STB=1 (sector %0d), required no step", SECTOR);
      end else begin
        e = sb_q.pop_front();
        chk("step_sector", 32'(SECTOR), 32'(e.sec));
        chk("step_dir", 32'(DIR), 32'(e.dir));
        chk("step_pvalid", 32'(PERIOD_VALID), 32'(e.pv));
        if (e.pv) chk("step_period", 32'(PERIOD), 32'(e.per));
      end
    end
  end

  initial begin
    // forward lap, then forward to 3, reverse back to 0
    vecs[0]  = '{3'b100, 1'b1, 3'd1, 1'b1, 1'b0, 24'd200};
    vecs[1]  = '{3'b110, 1'b1, 3'd2, 1'b1, 1'b1, 24'd200};
    vecs[2]  = '{3'b010, 1'b1, 3'd3, 1'b1, 1'b1, 24'd200};
    vecs[3]  = '{3'b011, 1'b1, 3'd4, 1'b1, 1'b1, 24'd200};
    vecs[4]  = '{3'b001, 1'b1, 3'd5, 1'b1, 1'b1, 24'd200};
    vecs[5]  = '{3'b101, 1'b1, 3'd0, 1'b1, 1'b1, 24'd200};
    vecs[6]  = '{3'b100, 1'b1, 3'd1, 1'b1, 1'b1, 24'd200};
    vecs[7]  = '{3'b110, 1'b1, 3'd2, 1'b1, 1'b1, 24'd200};
    vecs[8]  = '{3'b010, 1'b1, 3'd3, 1'b1, 1'b1, 24'd200};
    vecs[9]  = '{3'b110, 1'b1, 3'd2, 1'b0, 1'b0, 24'd200};
    vecs[10] = '{3'b100, 1'b1, 3'd1, 1'b0, 1'b1, 24'd200};
    vecs[11] = '{3'b101, 1'b1, 3'd0, 1'b0, 1'b1, 24'd200};

    // Reset state
    tick(3);
    chk("rst_sector", 32'(SECTOR), 32'd0);
    chk("rst_svalid", 32'(SECTOR_VALID), 32'd0);
    chk("rst_dir", 32'(DIR), 32'd1);
    chk("rst_step", 32'(STEP_STB), 32'd0);
    chk("rst_period", 32'(PERIOD), 32'd0);
    chk("rst_pvalid", 32'(PERIOD_VALID), 32'd0);
    chk("rst_stall", 32'(STALL), 32'd0);
    chk("rst_err", 32'(HALL_ERR), 32'd0);

    // First code: visible exactly 7 edges after release
    RST_N = 1'b1;
    tick(6);
    chk("lat_svalid_early", 32'(SECTOR_VALID), 32'd0);
    tick(1);
    chk("lat_svalid", 32'(SECTOR_VALID), 32'd1);
    chk("lat_sector", 32'(SECTOR), 32'd0);
    chk("lat_dir", 32'(DIR), 32'd1);
    chk("lat_err", 32'(HALL_ERR), 32'd0);
    tick(50);

    // Table-driven steps, 200 cycles per code
    for (int i = 0; i < 12; i++) begin
      HALL = vecs[i].hall;
      if (vecs[i].step) push_step(vecs[i].sec, vecs[i].dir, vecs[i].pv, vecs[i].per);
      tick(200);
      chk("vec_sector", 32'(SECTOR), 32'(vecs[i].sec));
      chk("vec_svalid", 32'(SECTOR_VALID), 32'd1);
      chk("vec_dir", 32'(DIR), 32'(vecs[i].dir));
      chk("vec_pvalid", 32'(PERIOD_VALID), 32'(vecs[i].pv));
      chk("vec_err", 32'(HALL_ERR), 32'd0);
      if (vecs[i].pv) chk("vec_period", 32'(PERIOD), 32'(vecs[i].per));
    end

    // 3-cycle glitch is filtered out
    HALL = 3'b100; tick(3); HALL = 3'b101; tick(20);
    chk("glitch3_sector", 32'(SECTOR), 32'd0);
    chk("glitch3_dir", 32'(DIR), 32'd0);
    chk("glitch3_pvalid", 32'(PERIOD_VALID), 32'd1);

    // 4-cycle glitch passes: forward to 1, then reverse to 0
    push_step(3'd1, 1'b1, 1'b0, '0);
    push_step(3'd0, 1'b0, 1'b0, '0);
    HALL = 3'b100; tick(4); HALL = 3'b101; tick(20);
    chk("glitch4_sector", 32'(SECTOR), 32'd0);
    chk("glitch4_dir", 32'(DIR), 32'd0);
    chk("glitch4_sb_empty", 32'(sb_q.size()), 32'd0);

    // Illegal code, recovery without a step, sticky error
    HALL = 3'b111; tick(20);
    chk("ill_svalid", 32'(SECTOR_VALID), 32'd0);
    chk("ill_sector", 32'(SECTOR), 32'd0);
    chk("ill_err", 32'(HALL_ERR), 32'd1);
    HALL = 3'b101; tick(20);
    chk("rec_svalid", 32'(SECTOR_VALID), 32'd1);
    chk("rec_err_sticky", 32'(HALL_ERR), 32'd1);
    clr_pulse();
    chk("clr_err", 32'(HALL_ERR), 32'd0);

    // Set and clear on the same edge: set wins
    HALL = 3'b000; tick(6);
    chk("z_svalid_early", 32'(SECTOR_VALID), 32'd1);
    clr_pulse();
    chk("setclr_err", 32'(HALL_ERR), 32'd1);
    chk("z_svalid", 32'(SECTOR_VALID), 32'd0);
    tick(5);
    clr_pulse();
    chk("clr_alone_err", 32'(HALL_ERR), 32'd0);
    chk("z_sector_held", 32'(SECTOR), 32'd0);

    // Stall after a valid measurement
    HALL = 3'b101; tick(200);
    HALL = 3'b100; push_step(3'd1, 1'b1, 1'b0, '0); tick(200);
    HALL = 3'b110; push_step(3'd2, 1'b1, 1'b1, 24'd200); tick(7);
    chk("st_pvalid0", 32'(PERIOD_VALID), 32'd1);
    tick(998);
    chk("st_stall_early", 32'(STALL), 32'd0);
    chk("st_pvalid_early", 32'(PERIOD_VALID), 32'd1);
    tick(1);
    chk("st_stall", 32'(STALL), 32'd1);
    chk("st_pvalid", 32'(PERIOD_VALID), 32'd0);
    HALL = 3'b010; push_step(3'd3, 1'b1, 1'b0, '0); tick(6);
    chk("st_stall_hold", 32'(STALL), 32'd1);
    tick(1);
    chk("st_stall_clr", 32'(STALL), 32'd0);
    chk("st_sector", 32'(SECTOR), 32'd3);

    // Skips 3->0 and 0->3
    HALL = 3'b101; tick(20);
    chk("skip_sector", 32'(SECTOR), 32'd0);
    chk("skip_err", 32'(HALL_ERR), 32'd1);
    chk("skip_dir", 32'(DIR), 32'd1);
    chk("skip_pvalid", 32'(PERIOD_VALID), 32'd0);
    clr_pulse();
    chk("skip_clr", 32'(HALL_ERR), 32'd0);
    HALL = 3'b010; tick(20);
    chk("skip2_sector", 32'(SECTOR), 32'd3);
    chk("skip2_err", 32'(HALL_ERR), 32'd1);

    // Reset mid-filter discards the pending step
    HALL = 3'b011; tick(3);
    RST_N = 1'b0; #1;
    chk("mrst_sector", 32'(SECTOR), 32'd0);
    chk("mrst_svalid", 32'(SECTOR_VALID), 32'd0);
    chk("mrst_err", 32'(HALL_ERR), 32'd0);
    tick(2);
    RST_N = 1'b1;
    tick(7);
    chk("mrst_rec_svalid", 32'(SECTOR_VALID), 32'd1);
    chk("mrst_rec_sector", 32'(SECTOR), 32'd4);
    chk("mrst_rec_dir", 32'(DIR), 32'd1);
    tick(5);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
